// File: rtl/uarch_pkg.sv
// Shared LSQ/memory types: request bundle, arbiter states, age compare.
// Default field widths match lsq_mem_arbiter's default ADDR_W/DATA_W.
package uarch_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    // Age stamps are wrapping sequence numbers of width w (w <= 32).
    // a is older than b when (a - b) is negative as a w-bit signed value.
    function automatic logic is_older(logic [31:0] a, logic [31:0] b,
                                      int unsigned w);
        logic [31:0] d;
        d = (a - b) << (32 - w);
        return d[31];
    endfunction

endpackage

// File: rtl/lsq_age_pick.sv
// Two-way age picker with starvation override; one-hot grant out.
// Ports: a_valid/a_age, b_valid/b_age, force_b, grant[0]=a, grant[1]=b.
module lsq_age_pick
    import uarch_pkg::*;
#(
    parameter int AGE_W = 8
) (
    input  logic             a_valid,
    input  logic [AGE_W-1:0] a_age,
    input  logic             b_valid,
    input  logic [AGE_W-1:0] b_age,
    input  logic             force_b,
    output logic [1:0]       grant
);

    logic a_old;

    assign a_old = is_older(32'(a_age), 32'(b_age), AGE_W);

    always_comb begin
        grant = 2'b00;
        if (a_valid && b_valid) begin
            grant = (force_b || !a_old) ? 2'b10 : 2'b01;
        end else if (a_valid) begin
            grant = 2'b01;
        end else if (b_valid) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Single D-cache port sequencer for LSQ loads and committed stores.
// Ports: clk, rst (async, active-high), flush; ld_req_* / st_req_* from
// LSQ and store queue; mem_req_* / mem_resp_* to the cache; ld_resp_*
// to CDB writeback. Define LSQ_ARB_PERF_EN to add perf_* counters.
module lsq_mem_arbiter
    import uarch_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 6,
    parameter int AGE_W        = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [2:0]        ld_req_funct3,
    input  logic [TAG_W-1:0]  ld_req_tag,
    input  logic [AGE_W-1:0]  ld_req_age,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    input  logic [2:0]        st_req_funct3,
    input  logic [AGE_W-1:0]  st_req_age,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [2:0]        mem_req_funct3,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
`ifdef LSQ_ARB_PERF_EN
    output logic [31:0]       perf_ld_grants,
    output logic [31:0]       perf_st_grants,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic              ld_resp_valid,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic [DATA_W-1:0] ld_resp_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_q;
    arb_state_e        state_d;
    mem_req_t          req_q;
    logic [TAG_W-1:0]  tag_q;
    logic              kill_q;
    logic [CNT_W-1:0]  starve_q;
    logic              resp_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [DATA_W-1:0] resp_data_q;

    logic       idle;
    logic       is_ld;
    logic [1:0] grant;

    // No grants while reset is held so every output reads 0 in reset.
    assign idle  = (state_q == IDLE) && !rst && !flush;
    assign is_ld = !req_q.we;

    lsq_age_pick #(
        .AGE_W (AGE_W)
    ) u_pick (
        .a_valid (ld_req_valid && idle),
        .a_age   (ld_req_age),
        .b_valid (st_req_valid && idle),
        .b_age   (st_req_age),
        .force_b (starve_q == LIMIT),
        .grant   (grant)
    );

    assign ld_req_ready = grant[0];
    assign st_req_ready = grant[1];

    assign mem_req_valid  = (state_q == ISSUE);
    assign mem_req_we     = req_q.we;
    assign mem_req_addr   = req_q.addr;
    assign mem_req_wdata  = req_q.wdata;
    assign mem_req_funct3 = req_q.funct3;

    // A registered load result is squashed if flush lands on it.
    assign ld_resp_valid = resp_q && !flush;
    assign ld_resp_tag   = resp_tag_q;
    assign ld_resp_data  = resp_data_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) state_d = ISSUE;
            end
            ISSUE: begin
                // The cache cannot retract an accepted load, so a killed
                // load still has to drain its response.
                if (mem_req_ready) begin
                    state_d = (is_ld && (kill_q || flush)) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid)      state_d = IDLE;
                else if (is_ld && flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            tag_q       <= '0;
            kill_q      <= 1'b0;
            starve_q    <= '0;
            resp_q      <= 1'b0;
            resp_tag_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;

            if (grant[0]) begin
                req_q <= '{we: 1'b0, addr: ld_req_addr, wdata: '0,
                           funct3: ld_req_funct3};
                tag_q <= ld_req_tag;
            end else if (grant[1]) begin
                req_q <= '{we: 1'b1, addr: st_req_addr, wdata: st_req_data,
                           funct3: st_req_funct3};
            end

            if (|grant) begin
                kill_q <= 1'b0;
            end else if (state_q == ISSUE && is_ld && flush) begin
                kill_q <= 1'b1;
            end

            if (!st_req_valid || grant[1]) begin
                starve_q <= '0;
            end else if (grant[0] && starve_q != LIMIT) begin
                starve_q <= starve_q + 1'b1;
            end

            resp_q <= (state_q == WAIT) && mem_resp_valid && is_ld && !flush;
            if (state_q == WAIT && mem_resp_valid && is_ld) begin
                resp_tag_q  <= tag_q;
                resp_data_q <= mem_resp_rdata;
            end
        end
    end

`ifdef LSQ_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ld_grants    <= '0;
            perf_st_grants    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (grant[0]) perf_ld_grants <= perf_ld_grants + 1'b1;
            if (grant[1]) perf_st_grants <= perf_st_grants + 1'b1;
            if (state_q == ISSUE && !mem_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter.
// Inputs change #1 after posedge; outputs are checked before the next edge.
module tb_lsq_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [2:0]  ld_req_funct3;
    logic [5:0]  ld_req_tag;
    logic [7:0]  ld_req_age;
    logic        st_req_valid;
    logic        st_req_ready;
    logic [31:0] st_req_addr;
    logic [31:0] st_req_data;
    logic [2:0]  st_req_funct3;
    logic [7:0]  st_req_age;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [2:0]  mem_req_funct3;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        ld_resp_valid;
    logic [5:0]  ld_resp_tag;
    logic [31:0] ld_resp_data;
`ifdef LSQ_ARB_PERF_EN
    logic [31:0] perf_ld_grants;
    logic [31:0] perf_st_grants;
    logic [31:0] perf_stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    lsq_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .ld_req_valid   (ld_req_valid),
        .ld_req_ready   (ld_req_ready),
        .ld_req_addr    (ld_req_addr),
        .ld_req_funct3  (ld_req_funct3),
        .ld_req_tag     (ld_req_tag),
        .ld_req_age     (ld_req_age),
        .st_req_valid   (st_req_valid),
        .st_req_ready   (st_req_ready),
        .st_req_addr    (st_req_addr),
        .st_req_data    (st_req_data),
        .st_req_funct3  (st_req_funct3),
        .st_req_age     (st_req_age),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_funct3 (mem_req_funct3),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
`ifdef LSQ_ARB_PERF_EN
        .perf_ld_grants    (perf_ld_grants),
        .perf_st_grants    (perf_st_grants),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_tag    (ld_resp_tag),
        .ld_resp_data   (ld_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From ISSUE: cache accepts, then answers on the following cycle.
    task automatic finish_txn(input logic [31:0] data);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = data;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ld_req_valid = 1'b0;
        ld_req_addr = '0;
        ld_req_funct3 = 3'd2;
        ld_req_tag = '0;
        ld_req_age = '0;
        st_req_valid = 1'b0;
        st_req_addr = '0;
        st_req_data = '0;
        st_req_funct3 = 3'd2;
        st_req_age = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;

        // reset
        #2;
        ld_req_valid = 1'b1;
        #1;
        chk("rst_ld_ready", ld_req_ready, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_resp_valid", ld_resp_valid, 0);
        chk("rst_addr", mem_req_addr, 0);
        ld_req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // load only
        ld_req_valid = 1'b1;
        ld_req_addr = 32'h100;
        ld_req_tag = 6'd5;
        ld_req_age = 8'd1;
        #1;
        chk("ld_grant", {ld_req_ready, st_req_ready}, 2'b10);
        tick();
        ld_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("ld_issue_valid", mem_req_valid, 1);
        chk("ld_issue_we", mem_req_we, 0);
        chk("ld_issue_addr", mem_req_addr, 32'h100);
        chk("ld_issue_f3", mem_req_funct3, 3'd2);
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("ld_wait_valid", mem_req_valid, 0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_resp_early", ld_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("ld_resp_valid", ld_resp_valid, 1);
        chk("ld_resp_tag", ld_resp_tag, 6'd5);
        chk("ld_resp_data", ld_resp_data, 32'hDEADBEEF);
        tick();
        chk("ld_resp_pulse", ld_resp_valid, 0);

        // age pick: store older
        ld_req_valid = 1'b1;
        ld_req_age = 8'd10;
        ld_req_addr = 32'h300;
        st_req_valid = 1'b1;
        st_req_age = 8'd7;
        st_req_addr = 32'h400;
        st_req_data = 32'h1234;
        #1;
        chk("age_st_older", {ld_req_ready, st_req_ready}, 2'b01);
        tick();
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        #1;
        chk("st_issue_we", mem_req_we, 1);
        chk("st_issue_addr", mem_req_addr, 32'h400);
        chk("st_issue_wdata", mem_req_wdata, 32'h1234);
        finish_txn(32'h0);
        #1;
        chk("st_no_resp", ld_resp_valid, 0);

        // age pick across wrap: 0x02 is younger than 0xFE
        ld_req_valid = 1'b1;
        ld_req_age = 8'h02;
        st_req_valid = 1'b1;
        st_req_age = 8'hFE;
        #1;
        chk("age_wrap", {ld_req_ready, st_req_ready}, 2'b01);
        tick();
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        finish_txn(32'h0);

        // starvation guard
        st_req_valid = 1'b1;
        st_req_age = 8'd100;
        st_req_addr = 32'h500;
        ld_req_valid = 1'b1;
        ld_req_age = 8'd5;
        ld_req_addr = 32'h600;
        ld_req_tag = 6'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_ld", {ld_req_ready, st_req_ready}, 2'b10);
            tick();
            finish_txn(32'(i));
        end
        #1;
        chk("starve_force_st", {ld_req_ready, st_req_ready}, 2'b01);
        tick();
        #1;
        chk("starve_st_we", mem_req_we, 1);
        finish_txn(32'h0);
        #1;
        chk("starve_cleared", {ld_req_ready, st_req_ready}, 2'b10);
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        tick();

        // cache stall in ISSUE
        ld_req_valid = 1'b1;
        ld_req_addr = 32'h700;
        ld_req_tag = 6'd9;
        ld_req_age = 8'd1;
        #1;
        chk("stall_grant", ld_req_ready, 1);
        tick();
        ld_req_addr = 32'h7FC;
        st_req_valid = 1'b1;
        st_req_age = 8'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", mem_req_valid, 1);
            chk("stall_addr", mem_req_addr, 32'h700);
            chk("stall_no_grant", {ld_req_ready, st_req_ready}, 2'b00);
            tick();
        end
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        finish_txn(32'h77);
        #1;
        chk("stall_resp_tag", ld_resp_tag, 6'd9);
`ifdef LSQ_ARB_PERF_EN
        chk("perf_stall", perf_stall_cycles, 5);
        chk("perf_ld", perf_ld_grants, 6);
        chk("perf_st", perf_st_grants, 3);
`endif
        tick();

        // flush in IDLE blocks grants
        flush = 1'b1;
        ld_req_valid = 1'b1;
        #1;
        chk("flush_idle", ld_req_ready, 0);
        flush = 1'b0;
        ld_req_valid = 1'b0;
        tick();

        // flush during WAIT of load tag 3
        ld_req_valid = 1'b1;
        ld_req_tag = 6'd3;
        ld_req_addr = 32'h800;
        tick();
        ld_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ld_req_valid = 1'b1;
        #1;
        chk("drain_no_grant", ld_req_ready, 0);
        ld_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("drain_no_resp", ld_resp_valid, 0);
        ld_req_valid = 1'b1;
        #1;
        chk("drain_to_idle", ld_req_ready, 1);
        ld_req_valid = 1'b0;
        tick();
        chk("drain_no_resp2", ld_resp_valid, 0);

        // flush during ISSUE of a load: presented, then drained
        ld_req_valid = 1'b1;
        ld_req_tag = 6'd8;
        tick();
        ld_req_valid = 1'b0;
        flush = 1'b1;
        mem_req_ready = 1'b1;
        #1;
        chk("flush_issue_valid", mem_req_valid, 1);
        tick();
        flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("flush_issue_no_resp", ld_resp_valid, 0);

        // flush during WAIT of a store
        st_req_valid = 1'b1;
        st_req_addr = 32'h900;
        st_req_data = 32'hCAFE;
        st_req_age = 8'd3;
        #1;
        chk("fst_grant", st_req_ready, 1);
        tick();
        st_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ld_req_valid = 1'b1;
        ld_req_addr = 32'hA00;
        ld_req_tag = 6'd4;
        ld_req_age = 8'd9;
        #1;
        chk("fst_wait_no_grant", ld_req_ready, 0);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("fst_next_grant", ld_req_ready, 1);
        tick();
        ld_req_valid = 1'b0;
        #1;
        chk("fst_next_issue", mem_req_valid, 1);
        chk("fst_next_addr", mem_req_addr, 32'hA00);
        finish_txn(32'h55);
        #1;
        chk("fst_next_resp", ld_resp_valid, 1);
        chk("fst_next_tag", ld_resp_tag, 6'd4);
        chk("fst_next_data", ld_resp_data, 32'h55);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
